// File: rtl/hack_pc_unit_pkg.sv
// Shared Hack datapath types: jump-field encodings, the machine word and PC states.
package hack_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    // Jump field: [2] = jump if negative, [1] = jump if zero, [0] = jump if positive
    localparam logic [2:0] JMP_NULL = 3'b000;
    localparam logic [2:0] JMP_JGT  = 3'b001;
    localparam logic [2:0] JMP_JEQ  = 3'b010;
    localparam logic [2:0] JMP_JGE  = 3'b011;
    localparam logic [2:0] JMP_JLT  = 3'b100;
    localparam logic [2:0] JMP_JNE  = 3'b101;
    localparam logic [2:0] JMP_JLE  = 3'b110;
    localparam logic [2:0] JMP_JMP  = 3'b111;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage

// File: rtl/hack_pc_unit_if.sv
// Connects the upstream mux / control / ALU flags to the PC stage, and carries the PC outputs back.
interface hack_pc_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic             jump_en;
    logic [2:0]       jmp;
    logic             zr;
    logic             ng;
    logic             inc;
    logic             stall;
    logic [WIDTH-1:0] pc;
    logic             taken;
    logic             wrap;
    logic             halted;

    modport master (
        output in, jump_en, jmp, zr, ng, inc, stall,
        input  pc, taken, wrap, halted
    );

    modport slave (
        input  in, jump_en, jmp, zr, ng, inc, stall,
        output pc, taken, wrap, halted
    );
endinterface

// File: rtl/hack_jump_cond.sv
// Jump condition decode: compares the C-instruction jump bits with the ALU flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is acted on.
module hack_jump_cond (
    input  logic [2:0] jmp,
    input  logic       zr,
    input  logic       ng,
    input  logic       jump_en,
    output logic       cond
);
    logic pos;

    // zr & ng together is not a legal ALU result; it is decoded literally so both terms fire
    assign pos  = !zr && !ng;
    assign cond = jump_en && ((jmp[2] && ng) || (jmp[1] && zr) || (jmp[0] && pos));

endmodule

// File: rtl/hack_pc_unit.sv
// Program counter: loads a jump target, increments, or holds; freezes on the self-jump halt idiom.
// Latency: one cycle from inputs to pc/taken/wrap; halted follows the halting jump by one more cycle.
// Backpressure: stall holds pc and drops any jump or increment presented that cycle.
module hack_pc_unit
    import hack_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic         clk,
    input  logic         reset,
    hack_pc_unit_if.slave bus
);

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] pc_q, pc_nxt;
    logic             taken_q, taken_nxt;
    logic             wrap_q, wrap_nxt;
    logic             halted_q;
    logic             cond;

    hack_jump_cond u_jump_cond (
        .jmp     (bus.jmp),
        .zr      (bus.zr),
        .ng      (bus.ng),
        .jump_en (bus.jump_en),
        .cond    (cond)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        taken_nxt = 1'b0;
        wrap_nxt  = 1'b0;
        if (state_q == RUN && !bus.stall) begin
            if (cond) begin
                pc_nxt    = bus.in;
                taken_nxt = 1'b1;
                // Unconditional jump to the current address is the program's halt idiom
                if (bus.in == pc_q && bus.jmp == JMP_JMP) begin
                    state_nxt = HALT;
                end
            end else if (bus.inc) begin
                pc_nxt   = pc_q + WIDTH'(1);
                wrap_nxt = &pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_VECTOR;
            taken_q  <= 1'b0;
            wrap_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_nxt;
            taken_q  <= taken_nxt;
            wrap_q   <= wrap_nxt;
            halted_q <= (state_q == HALT);
        end
    end

    assign bus.pc     = pc_q;
    assign bus.taken  = taken_q;
    assign bus.wrap   = wrap_q;
    assign bus.halted = halted_q;

endmodule

// File: doc/hack_pc_unit.md
Name: hack_pc_unit

Overview:
- Program-counter stage sitting directly downstream of the 16-bit A/instruction select mux in the Hack-style CPU datapath.
- Evaluates the C-instruction jump condition against the ALU flags, then either loads the mux-selected target, increments, or holds.
- Detects the canonical halt idiom (unconditional jump to the current address) and freezes.
- Output drives instruction-memory address.

Parameters:
- WIDTH, 16, datapath and address width
- RESET_VECTOR, 0, value loaded into pc on reset

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in  input  WIDTH  jump target (selected A-register value from the upstream mux)
- jump_en  input  1  current instruction is a C-instruction; qualifies jmp
- jmp  input  3  jump bits j1 j2 j3: [2] = jump if negative, [1] = jump if zero, [0] = jump if positive
- zr  input  1  ALU output is zero
- ng  input  1  ALU output is negative
- inc  input  1  advance to next instruction
- stall  input  1  freeze pc this cycle
- pc  output  WIDTH  registered program counter
- taken  output  1  registered; 1 for the cycle after a jump was loaded
- wrap  output  1  registered; 1 for the cycle after an increment wrapped to 0
- halted  output  1  registered; sticky halt indication

Behaviour:
- Interface:
  - One clock, clk.
  - Reset is synchronous and active-high, port reset.
  - All state updates occur on the rising edge of clk.
- Reset values:
  - pc = RESET_VECTOR.
  - taken = 0, wrap = 0, halted = 0.
  - state = RUN.
- Condition decode, combinational:
  - pos = !zr & !ng.
  - cond = jump_en & ((jmp[2]&ng) | (jmp[1]&zr) | (jmp[0]&pos)).
  - zr=1 with ng=1 is an illegal ALU flag combination. It is evaluated literally: pos = 0, and the jmp[2] and jmp[1] terms both apply.
- Next-state priority, evaluated each edge:
  1. reset → reset values.
  2. state == HALT → pc holds; taken and wrap are 0.
  3. stall → pc holds; taken and wrap are 0. A jump or inc asserted that cycle is dropped and not queued.
  4. cond → pc = in; taken = 1 next cycle.
  5. inc → pc = pc + 1 mod 2^WIDTH; wrap = 1 next cycle iff old pc was all-ones.
  6. Otherwise → hold.
- Latency: one cycle from input to pc. taken and wrap are asserted in the same cycle the new pc is visible.
- Jump outranks inc when both are asserted.
- Halt FSM, states RUN and HALT:
  - RUN → HALT when a jump is loaded (priority 4 taken) with in == pc and jmp == 3'b111.
  - On that edge, pc is reloaded with the same value and taken = 1.
  - halted = 1 from the following cycle.
  - A conditional self-jump (jmp != 3'b111) does not halt.
  - HALT → RUN only on reset. halted stays 1 until then.
- Reset mid-jump or mid-halt: reset wins unconditionally, clears halted, and returns to RUN the next cycle.
- All outputs are registered. No combinational input-to-output path.

Decomposition:
- Shared package (hack_pkg):
  - Constants JMP_NULL=3'b000 through JMP_JMP=3'b111 (JGT, JEQ, JGE, JLT, JNE, JLE).
  - Type alias for a WIDTH-bit word.
  - State enum {RUN, HALT}.
- One natural sub-module: hack_jump_cond, purely combinational (jmp, zr, ng, jump_en → cond). It is reused by the later ALU-flag checker.
- The pc register, priority logic and FSM stay in hack_pc_unit.

Test Plan:
- Reset then inc=1 for 3 cycles: pc goes 0 → 1 → 2 → 3. taken=0, wrap=0, halted=0 throughout.
- pc=5, jump_en=1, jmp=3'b010 (JEQ), zr=1, ng=0, in=16'h0040, inc=1: next pc=16'h0040, taken=1 for one cycle. Repeat with zr=0: pc=6, taken=0.
- Jump decode sweep:
  - Each jmp value 0–7 against each flag state (ng=1; zr=1; both 0) with in=16'h1234.
  - pc matches the table, e.g. JLE with pos → increments; JNE with ng → loads 16'h1234.
  - jump_en=0 never loads.
- pc=16'hFFFF, inc=1: pc=16'h0000, wrap=1 for exactly one cycle.
- stall=1 with cond true and inc=1: pc unchanged, taken=0. Deassert stall with no jump/inc: pc still unchanged (jump not queued).
- Halt then reset:
  - pc=16'h0010, in=16'h0010, jmp=3'b111, jump_en=1: taken=1, then halted=1.
  - Further jumps/incs are ignored for 5 cycles.
  - reset=1 for one cycle: pc=0, halted=0, and inc resumes counting.
